// File: rtl/uart_word_rx.sv
// UART 8N1 receiver packing four bytes (MSB byte first) into 32-bit words.
// Define UART_WORD_TIMEOUT_EN to drop partial words after a long idle gap.
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 868
`ifdef UART_WORD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 40
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_pin,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e state_q, state_d;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          rx, fall, tick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic [23:0]   wsr_q, wsr_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   word_q, word_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

`ifdef UART_WORD_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] idle_q, idle_d;
`endif

    assign rx   = rx_s2_q;
    assign fall = rx_prev_q & ~rx_s2_q;
    assign tick = (cnt_q == LAST);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            wsr_q     <= '0;
            bcnt_q    <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_s1_q   <= uart_rx_pin;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            wsr_q     <= wsr_d;
            bcnt_q    <= bcnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef UART_WORD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (fall) state_d = S_START;
            S_START: if (cnt_q == HALF) state_d = rx ? S_IDLE : S_DATA;
            S_DATA:  if (tick && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath and registered outputs
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        wsr_d   = wsr_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        valid_d = valid_q & ~word_ready_i;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: cnt_d = '0;
            S_START: begin
                bit_d = '0;
                if (cnt_q == HALF) cnt_d = '0;
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d  = '0;
                    byte_d = {rx, byte_q[7:1]};
                    bit_d  = bit_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (rx) begin
                        bcnt_d = bcnt_q + 1'b1;
                        wsr_d  = {wsr_q[15:0], byte_q};
                        if (bcnt_q == 2'd3) begin
                            if (!valid_q || word_ready_i) begin
                                word_d  = {wsr_q, byte_q};
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end else begin
                        ferr_d = 1'b1;
                        bcnt_d = '0;
                        wsr_d  = '0;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
`ifdef UART_WORD_TIMEOUT_EN
        // a start edge restarts the count; leaving IDLE also clears it
        idle_d = '0;
        if (state_q == S_IDLE && bcnt_q != 2'd0 && !fall) begin
            if (idle_q == TW'(TO_CYC - 1)) begin
                bcnt_d = '0;
                wsr_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    // outputs
    always_comb begin
        word_o       = word_q;
        word_valid_o = valid_q;
        frame_err_o  = ferr_q;
        overrun_o    = ovr_q;
        busy_o       = (state_q != S_IDLE) || (bcnt_q != 2'd0);
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed steps plus random bytes
// against a byte-queue model of word assembly.
module tb_uart_word_rx;

    localparam int CPB = 64;
    localparam int TOB = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pin = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        busy_o;

    always #5 clk = ~clk;

    uart_word_rx #(
        .CLKS_PER_BIT(CPB)
`ifdef UART_WORD_TIMEOUT_EN
        ,
        .TIMEOUT_BITS(TOB)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_pin (pin),
        .word_o      (word_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(rdy),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          valid_hi = 0;
    int          exp_ferr = 0;
    int          exp_ovr = 0;
    bit          mdl_full = 1'b0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  part_q[$];

    always @(negedge clk) begin
        if (word_valid_o && rdy) got_q.push_back(word_o);
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (word_valid_o) valid_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference: bytes collect in order; four good bytes make a word
    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [31:0] w;
        if (!ok) begin
            part_q.delete();
            exp_ferr++;
        end else begin
            part_q.push_back(b);
            if (part_q.size() == 4) begin
                w = {part_q[0], part_q[1], part_q[2], part_q[3]};
                part_q.delete();
                if (mdl_full) exp_ovr++;
                else begin
                    exp_q.push_back(w);
                    if (!rdy) mdl_full = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        if (mdl_full) void'(exp_q.pop_back());
        mdl_full = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        pin = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            pin = b[i];
            wait_clks(CPB);
        end
        pin = ok;
        wait_clks(CPB);
        pin = 1'b1;
        if (!ok) wait_clks(CPB);
        model_byte(b, ok);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], 1'b1);
    endtask

    task automatic idle_bits(input int n);
        pin = 1'b1;
        wait_clks(n * CPB);
`ifdef UART_WORD_TIMEOUT_EN
        if (n >= TOB) part_q.delete();
`endif
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        chk({tag, "_ovr"}, ovr_cnt, exp_ovr);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] w0;
        #23;
        chk("rst_word", word_o, 32'h0);
        chk("rst_valid", word_valid_o, 1'b0);
        chk("rst_ferr", frame_err_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        wait_clks(3);
        rst = 1'b1;
        wait_clks(CPB);

        // 1: single word, consumer always ready
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEE, 1'b1);
        idle_bits(2);
        chk("t1_word", word_o, 32'h0000_00EE);
        chk("t1_valid_cycles", valid_hi, 1);
        check_all("t1");

        // 2: hold until ready
        rdy = 1'b0;
        send_word(32'h0000_0BD3);
        chk("t2_valid", word_valid_o, 1'b1);
        chk("t2_word", word_o, 32'h0000_0BD3);
        wait_clks(10);
        chk("t2_hold", word_valid_o, 1'b1);
        rdy = 1'b1;
        wait_clks(1);
        mdl_full = 1'b0;
        rdy = 1'b0;
        chk("t2_valid_clear", word_valid_o, 1'b0);
        check_all("t2");

        // 3: overrun while buffer full
        send_word(32'h0000_002A);
        send_word(32'h0000_004D);
        idle_bits(1);
        chk("t3_word", word_o, 32'h0000_002A);
        chk("t3_valid", word_valid_o, 1'b1);
        chk("t3_ovr_once", ovr_cnt, 1);
        rdy = 1'b1;
        wait_clks(1);
        mdl_full = 1'b0;
        idle_bits(1);
        check_all("t3");

        // 4: framing error mid-word
        send_byte(8'h11, 1'b1);
        send_byte(8'h5C, 1'b0);
        send_word(32'h0000_00D6);
        idle_bits(1);
        chk("t4_word", word_o, 32'h0000_00D6);
        chk("t4_ferr_once", ferr_cnt, 1);
        check_all("t4");

        // 5: short low glitch is rejected
        pin = 1'b0;
        wait_clks(20);
        chk("t5_busy_glitch", busy_o, 1'b1);
        pin = 1'b1;
        wait_clks(2 * CPB);
        chk("t5_busy_idle", busy_o, 1'b0);
        check_all("t5");

        // 6: long gap after a partial word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle_bits(50);
        send_word(32'hAABB_CCDD);
        idle_bits(2);
        w0 = (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx;
`ifdef UART_WORD_TIMEOUT_EN
        chk("t6_word", w0, 32'hAABB_CCDD);
`else
        chk("t6_word", w0, 32'h1122_33AA);
`endif
        check_all("t6");

        // 7: reset mid-byte with a word held
        rdy = 1'b0;
        send_word(32'h1234_5678);
        chk("t7_held", word_valid_o, 1'b1);
        pin = 1'b0;
        wait_clks(3 * CPB);
        #2 rst = 1'b0;
        #1;
        chk("t7_word", word_o, 32'h0);
        chk("t7_valid", word_valid_o, 1'b0);
        chk("t7_ferr", frame_err_o, 1'b0);
        chk("t7_ovr", overrun_o, 1'b0);
        chk("t7_busy", busy_o, 1'b0);
        model_reset();
        pin = 1'b1;
        wait_clks(4);
        rst = 1'b1;
        wait_clks(2 * CPB);
        rdy = 1'b1;
        send_word(32'hCAFE_F00D);
        idle_bits(2);
        chk("t7_after", word_o, 32'hCAFE_F00D);
        check_all("t7");

        // random bytes with occasional bad stop bits and short gaps
        for (int i = 0; i < 48; i++) begin
            send_byte(8'($urandom), $urandom_range(7) != 0);
            idle_bits($urandom_range(2));
        end
        idle_bits(2);
        check_all("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
